// File: rtl/abs_multi_ch.sv
// -----------------------------------------------------------------------------
// abs_multi_ch
//
// Multi-channel bipolar stochastic absolute-value unit.
//
// Each channel keeps a small saturating up/down counter that follows the
// density of ones in its bipolar bitstream. When the counter sits in its lower
// half the stream is taken to be negative. That sign estimate is used to
// produce |x|, -|x| or x as an output bitstream. The unit also reports the
// current sign estimate and a one-cycle pulse whenever the estimate flips.
//
// Parameters
//   CH    number of independent channels
//   DEP   sign-counter width in bits (>= 2)
//   INIT  counter value after reset / clear (0 .. 2**DEP-1)
//   OREG  0: out/sign/out_valid are combinational
//         1: out/sign/out_valid are registered (one cycle of latency)
//
// Ports
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous reset, active-high
//   value      in   CH    bipolar input bitstreams, one bit per channel
//   in_valid   in   CH    per-channel bit qualifier; counter moves only when 1
//   clr        in   CH    per-channel synchronous clear of the counter to INIT
//   mode       in   2     00 ABS, 01 NEG_ABS, 10 PASS, 11 treated as ABS
//   out        out  CH    result bitstreams
//   out_valid  out  CH    qualifier for out
//   sign       out  CH    1 = channel currently estimated negative
//   sign_chg   out  CH    one-cycle pulse after the sign estimate flips
// -----------------------------------------------------------------------------
module abs_multi_ch #(
  parameter int CH   = 4,
  parameter int DEP  = 3,
  parameter int INIT = 2 ** (DEP - 1),
  parameter int OREG = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] value,
  input  logic [CH-1:0] in_valid,
  input  logic [CH-1:0] clr,
  input  logic [1:0]    mode,
  output logic [CH-1:0] out,
  output logic [CH-1:0] out_valid,
  output logic [CH-1:0] sign,
  output logic [CH-1:0] sign_chg
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [DEP-1:0] L_INIT = DEP'(INIT);
  localparam logic [DEP-1:0] L_MAX  = '1;
  localparam logic [DEP-1:0] L_ZERO = '0;
  localparam logic [DEP-1:0] L_ONE  = DEP'(1);

  localparam logic [1:0] MODE_ABS     = 2'b00;
  localparam logic [1:0] MODE_NEG_ABS = 2'b01;
  localparam logic [1:0] MODE_PASS    = 2'b10;

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  logic [DEP-1:0] r_cnt      [CH];
  logic [DEP-1:0] w_cnt_next [CH];
  logic [CH-1:0]  r_sign_chg;

  logic [CH-1:0]  w_sign_c;
  logic [CH-1:0]  w_out_c;
  logic [CH-1:0]  w_msb_flip;

  // ---------------------------------------------------------------------------
  // Next-counter logic.
  // Priority is clr > in_valid > hold. The counter saturates at both ends
  // instead of wrapping: a wrap would flip the MSB and invert the sign
  // estimate on a long run of identical bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves it unassigned would infer a latch.
      w_cnt_next[i] = r_cnt[i];
      if (clr[i]) begin
        w_cnt_next[i] = L_INIT;
      end else if (in_valid[i]) begin
        if (value[i]) begin
          if (r_cnt[i] != L_MAX) begin
            w_cnt_next[i] = r_cnt[i] + L_ONE;
          end
        end else begin
          if (r_cnt[i] != L_ZERO) begin
            w_cnt_next[i] = r_cnt[i] - L_ONE;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sign estimate and output bit, both taken from the pre-update counter so
  // the bit being processed is judged by the history before it.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_sign_c[i]   = ~r_cnt[i][DEP-1];
      w_msb_flip[i] = w_cnt_next[i][DEP-1] ^ r_cnt[i][DEP-1];
      case (mode)
        MODE_NEG_ABS: w_out_c[i] = ~(value[i] ^ w_sign_c[i]);
        MODE_PASS:    w_out_c[i] = value[i];
        MODE_ABS:     w_out_c[i] = value[i] ^ w_sign_c[i];
        default:      w_out_c[i] = value[i] ^ w_sign_c[i];  // reserved code acts as ABS
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Counter and sign-change registers.
  // The sign-change pulse compares the MSB being loaded with the current MSB,
  // so a clear that moves the counter across the midpoint pulses as well.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counters are per-channel state registers, not a memory, so
      // they are all reset; the stream restarts from INIT on every channel.
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= L_INIT;
      end
      r_sign_chg <= '0;
    end else begin
      // NOTE: sequential state is assigned with <= so every register samples
      // the pre-edge values regardless of statement order.
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      r_sign_chg <= w_msb_flip;
    end
  end

  assign sign_chg = r_sign_chg;

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  generate
    if (OREG != 0) begin : g_oreg
      logic [CH-1:0] r_out;
      logic [CH-1:0] r_sign;
      logic [CH-1:0] r_out_valid;

      // out and sign only advance on qualified bits, so downstream logic sees
      // the last valid result held across in_valid gaps.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out       <= '0;
          r_sign      <= '0;
          r_out_valid <= '0;
        end else begin
          r_out_valid <= in_valid;
          for (int i = 0; i < CH; i++) begin
            if (in_valid[i]) begin
              r_out[i]  <= w_out_c[i];
              r_sign[i] <= w_sign_c[i];
            end
          end
        end
      end

      assign out       = r_out;
      assign sign      = r_sign;
      assign out_valid = r_out_valid;
    end else begin : g_comb
      assign out       = w_out_c;
      assign sign      = w_sign_c;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_abs_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_abs_multi_ch
//
// Drives one combinational-output instance and one registered-output instance
// of abs_multi_ch with identical stimulus. A behavioural model (integer
// counters with min/max saturation, "negative" = count below the midpoint)
// predicts each qualified output bit, sign estimate and sign-change pulse.
// The stimulus pushes predictions into per-channel queues; a monitor process
// pops them on the falling edge whenever a DUT presents out_valid.
// -----------------------------------------------------------------------------
module tb_abs_multi_ch;

  localparam int CH   = 4;
  localparam int DEP  = 3;
  localparam int INIT = 4;
  localparam int MAXC = 7;
  localparam int HALF = 4;

  localparam logic [1:0] ABS     = 2'b00;
  localparam logic [1:0] NEG_ABS = 2'b01;
  localparam logic [1:0] PASS    = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] value, in_valid, clr;
  logic [1:0]    mode;

  logic [CH-1:0] out0, ov0, sign0, chg0;
  logic [CH-1:0] out1, ov1, sign1, chg1;

  always #5 clk = ~clk;

  abs_multi_ch #(.CH(CH), .DEP(DEP), .INIT(INIT), .OREG(0)) u_comb (
    .clk(clk), .rst(rst), .value(value), .in_valid(in_valid), .clr(clr),
    .mode(mode), .out(out0), .out_valid(ov0), .sign(sign0), .sign_chg(chg0)
  );

  abs_multi_ch #(.CH(CH), .DEP(DEP), .INIT(INIT), .OREG(1)) u_reg (
    .clk(clk), .rst(rst), .value(value), .in_valid(in_valid), .clr(clr),
    .mode(mode), .out(out1), .out_valid(ov1), .sign(sign1), .sign_chg(chg1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int passed = 0;
  int total  = 0;

  int         model_cnt [CH];
  logic [1:0] q0 [CH][$];   // {out, sign} expected from the combinational DUT
  logic [1:0] q1 [CH][$];   // {out, sign} expected from the registered DUT
  logic       qc [CH][$];   // sign_chg expected one cycle after each edge
  logic       held_out  [CH];
  logic       held_sign [CH];

  task automatic check(input string name, input int ch, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s ch%0d: got %0d expected %0d at %0t", name, ch, act, exp, $time);
  endtask

  function automatic logic ref_out(input logic v, input logic neg, input logic [1:0] m);
    case (m)
      NEG_ABS: return neg ? v : ~v;    // -|x|: negative stream kept, positive inverted
      PASS:    return v;
      default: return neg ? ~v : v;    // |x|: negative stream inverted
    endcase
  endfunction

  // Apply one bit-time of stimulus (called just after a rising edge), record
  // predictions, advance the model, and move to just after the next edge.
  task automatic drive(input logic [CH-1:0] v, input logic [CH-1:0] iv,
                       input logic [CH-1:0] c, input logic [1:0] m);
    value = v; in_valid = iv; clr = c; mode = m;
    for (int i = 0; i < CH; i++) begin
      logic neg;
      int   nxt;
      neg = (model_cnt[i] < HALF);
      if (iv[i]) begin
        q0[i].push_back({ref_out(v[i], neg, m), neg});
        q1[i].push_back({ref_out(v[i], neg, m), neg});
      end
      nxt = model_cnt[i];
      if (c[i])       nxt = INIT;
      else if (iv[i]) nxt = v[i] ? ((nxt + 1 > MAXC) ? MAXC : nxt + 1)
                                 : ((nxt - 1 < 0) ? 0 : nxt - 1);
      qc[i].push_back((nxt < HALF) != (model_cnt[i] < HALF));
      model_cnt[i] = nxt;
    end
    @(posedge clk); #1;
  endtask

  // Asynchronous reset pulse in the second half of a bit-time.
  task automatic mid_reset();
    value = '0; in_valid = '0; clr = '0;
    for (int i = 0; i < CH; i++) qc[i].push_back(1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < CH; i++) begin
      check("rst_out_reg",   i, int'(out1[i]),  0);
      check("rst_ov_reg",    i, int'(ov1[i]),   0);
      check("rst_sign_reg",  i, int'(sign1[i]), 0);
      check("rst_chg_comb",  i, int'(chg0[i]),  0);
      check("rst_chg_reg",   i, int'(chg1[i]),  0);
      check("rst_sign_comb", i, int'(sign0[i]), (INIT < HALF) ? 1 : 0);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < CH; i++) begin
      q0[i].delete(); q1[i].delete(); qc[i].delete();
      model_cnt[i] = INIT;
      held_out[i]  = 1'b0;
      held_sign[i] = 1'b0;
      qc[i].push_back(1'b0);   // edge after reset sees idle inputs from INIT
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        logic [1:0] e;
        if (ov0[i]) begin
          if (q0[i].size() == 0) check("ov_comb_spurious", i, 1, 0);
          else begin
            e = q0[i].pop_front();
            check("out_comb",  i, int'(out0[i]),  int'(e[1]));
            check("sign_comb", i, int'(sign0[i]), int'(e[0]));
          end
        end
        if (ov1[i]) begin
          if (q1[i].size() == 0) check("ov_reg_spurious", i, 1, 0);
          else begin
            e = q1[i].pop_front();
            check("out_reg",  i, int'(out1[i]),  int'(e[1]));
            check("sign_reg", i, int'(sign1[i]), int'(e[0]));
            held_out[i]  = e[1];
            held_sign[i] = e[0];
          end
        end else begin
          check("out_reg_hold",  i, int'(out1[i]),  int'(held_out[i]));
          check("sign_reg_hold", i, int'(sign1[i]), int'(held_sign[i]));
        end
        if (qc[i].size() >= 2) begin
          logic ec;
          ec = qc[i].pop_front();
          check("chg_comb", i, int'(chg0[i]), int'(ec));
          check("chg_reg",  i, int'(chg1[i]), int'(ec));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int bias [CH];
    logic [1:0] rmode;
    bias = '{20, 45, 55, 80};
    rst = 1'b1; value = '0; in_valid = '0; clr = '0; mode = ABS;
    for (int i = 0; i < CH; i++) begin
      model_cnt[i] = INIT; held_out[i] = 1'b0; held_sign[i] = 1'b0;
    end
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // Run of ones: counters climb to all-ones and saturate.
    repeat (6) drive(4'hF, 4'hF, 4'h0, ABS);
    // Clear (wins over a valid zero), then run of zeros down to saturation at 0.
    drive(4'h0, 4'hF, 4'hF, ABS);
    repeat (5) drive(4'h0, 4'hF, 4'h0, ABS);
    // Up to 2, hold through in_valid gaps, then clear back across the midpoint.
    repeat (2) drive(4'hF, 4'hF, 4'h0, ABS);
    repeat (3) drive(4'h0, 4'h0, 4'h0, ABS);
    drive(4'h0, 4'hF, 4'hF, ABS);
    // Down to 1, then NEG_ABS and PASS on alternating data.
    repeat (3) drive(4'h0, 4'hF, 4'h0, ABS);
    for (int k = 0; k < 4; k++) drive((k % 2) ? 4'h5 : 4'hA, 4'hF, 4'h0, NEG_ABS);
    for (int k = 0; k < 4; k++) drive((k % 2) ? 4'h5 : 4'hA, 4'hF, 4'h0, PASS);
    // Clear, up to 6, then NEG_ABS on a positive stream.
    drive(4'h0, 4'h0, 4'hF, PASS);
    repeat (2) drive(4'hF, 4'hF, 4'h0, ABS);
    for (int k = 0; k < 4; k++) drive((k % 2) ? 4'h5 : 4'hA, 4'hF, 4'h0, NEG_ABS);
    // Burst on channel 2 with gaps; reserved mode code in the middle.
    drive(4'h4, 4'h4, 4'h0, ABS);
    drive(4'h0, 4'h0, 4'h0, ABS);
    drive(4'h0, 4'h4, 4'h0, 2'b11);
    drive(4'h4, 4'h0, 4'h0, ABS);
    drive(4'h4, 4'h0, 4'h0, ABS);
    drive(4'h0, 4'h4, 4'h0, ABS);
    drive(4'h4, 4'h4, 4'h0, ABS);
    drive(4'h0, 4'h0, 4'h0, ABS);

    // Randomised streams with per-channel density, mid-stream reset.
    rmode = ABS;
    for (int n = 0; n < 600; n++) begin
      logic [CH-1:0] v, iv, c;
      if (n % 20 == 0) rmode = 2'($urandom_range(0, 3));
      for (int i = 0; i < CH; i++) begin
        v[i]  = ($urandom_range(0, 99) < bias[i]);
        iv[i] = ($urandom_range(0, 99) < 75);
        c[i]  = ($urandom_range(0, 99) < 2);
      end
      if (n == 300) mid_reset();
      drive(v, iv, c, rmode);
    end

    repeat (3) drive(4'h0, 4'h0, 4'h0, ABS);
    @(negedge clk); #1;
    for (int i = 0; i < CH; i++) begin
      check("drain_comb", i, q0[i].size(), 0);
      check("drain_reg",  i, q1[i].size(), 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
